// File: rtl/wb_scoreboard.sv
// wb_scoreboard: register busy-bit scoreboard with ALU/load write-back arbitration.
// Ports:
//   cpu_clk, cpu_rst_n                    clock, synchronous active-low reset
//   issue_valid, issue_rd                 destination register leaving ID (marks it busy)
//   id_rs1_addr, id_rs2_addr              source registers read in ID
//   alu_valid, alu_rd, alu_data           ALU result, highest write-back priority
//   ld_valid, ld_rd, ld_data, ld_ready    load result handshake into the load queue
//   we, wd_addr, wd_data                  registered register-file write port
//   forward_detect_rs1/rs2                write-port-to-ID collision flags
//   hazard_stall                          ID must hold
module wb_scoreboard #(
    parameter int REGISTER_WIDTH          = 32,
    parameter int REGISTER_ADDR_WIDTH     = 5,
    parameter int LQ_DEPTH                = 2,
    parameter int FORWARD_COLLISION_IN_ID = 2
) (
    input  logic                           cpu_clk,
    input  logic                           cpu_rst_n,
    input  logic                           issue_valid,
    input  logic [REGISTER_ADDR_WIDTH-1:0] issue_rd,
    input  logic [REGISTER_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REGISTER_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                           alu_valid,
    input  logic [REGISTER_ADDR_WIDTH-1:0] alu_rd,
    input  logic [REGISTER_WIDTH-1:0]      alu_data,
    input  logic                           ld_valid,
    input  logic [REGISTER_ADDR_WIDTH-1:0] ld_rd,
    input  logic [REGISTER_WIDTH-1:0]      ld_data,
    output logic                           ld_ready,
    output logic                           we,
    output logic [REGISTER_ADDR_WIDTH-1:0] wd_addr,
    output logic [REGISTER_WIDTH-1:0]      wd_data,
    output logic [2:0]                     forward_detect_rs1,
    output logic [2:0]                     forward_detect_rs2,
    output logic                           hazard_stall
);
    localparam int NREG = 1 << REGISTER_ADDR_WIDTH;
    localparam int PW   = $clog2(LQ_DEPTH);
    localparam int CW   = PW + 1;

    logic [NREG-1:0]                r_busy;
    logic [REGISTER_ADDR_WIDTH-1:0] r_lq_rd   [LQ_DEPTH];
    logic [REGISTER_WIDTH-1:0]      r_lq_data [LQ_DEPTH];
    logic [PW-1:0]                  r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]                  r_count;

    logic [NREG-1:0]                w_set, w_clr;
    logic                           w_pop, w_push, w_full, w_sel_valid, w_we, w_fwd1, w_fwd2;
    logic [REGISTER_ADDR_WIDTH-1:0] w_sel_rd;
    logic [REGISTER_WIDTH-1:0]      w_sel_data;

    // Register 0 is never marked busy, so sources of x0 can never stall.
    assign w_set = (issue_valid && issue_rd != '0) ? NREG'(1) << issue_rd : '0;
    assign w_clr = we ? NREG'(1) << wd_addr : '0;

    assign w_full = r_count == CW'(LQ_DEPTH);
    assign w_pop  = !alu_valid && r_count != '0;
    // A full queue can still accept when its head drains this cycle.
    assign ld_ready = cpu_rst_n && (!w_full || w_pop);
    assign w_push   = ld_valid && ld_ready;

    assign w_sel_valid = alu_valid || w_pop;
    assign w_sel_rd    = alu_valid ? alu_rd   : r_lq_rd[r_rd_ptr];
    assign w_sel_data  = alu_valid ? alu_data : r_lq_data[r_rd_ptr];
    assign w_we        = w_sel_valid && w_sel_rd != '0;

    assign w_fwd1 = we && wd_addr != '0 && wd_addr == id_rs1_addr;
    assign w_fwd2 = we && wd_addr != '0 && wd_addr == id_rs2_addr;
    assign forward_detect_rs1 = 3'(w_fwd1) << FORWARD_COLLISION_IN_ID;
    assign forward_detect_rs2 = 3'(w_fwd2) << FORWARD_COLLISION_IN_ID;
    assign hazard_stall = (r_busy[id_rs1_addr] && !w_fwd1) || (r_busy[id_rs2_addr] && !w_fwd2);

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            r_busy   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            we       <= 1'b0;
            wd_addr  <= '0;
            wd_data  <= '0;
        end else begin
            // Set wins over a same-cycle clear of the same register.
            r_busy <= w_set | (r_busy & ~w_clr);
            if (w_push) begin
                r_lq_rd[r_wr_ptr]   <= ld_rd;
                r_lq_data[r_wr_ptr] <= ld_data;
                r_wr_ptr            <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            we      <= w_we;
            wd_addr <= w_we ? w_sel_rd : '0;
            wd_data <= w_we ? w_sel_data : '0;
        end
    end
endmodule
